rr_arbiter_3to8_src: RTL and testbench
======================================

Name: rr_arbiter_3to8_src

Overview:
- Round-robin arbiter for 8 requesters. Produces a registered 3-bit grant index plus a grant-valid strobe.
- Sits directly upstream of the 3-to-8 decoder: grant_idx drives the decoder's select input and grant_valid drives its enable, so the decoder output is the one-hot grant vector.
- Guarantees at most one grant at a time, fair rotation, bounded hold time, and one dead cycle between owners.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant before forced release. Legal range 2..256.
- CNT_W, $clog2(MAX_HOLD), width of the hold counter. Derived; not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  8  request vector; bit i = requester i wants the resource; level-sensitive.
- done  input  1  current owner releases the grant this cycle; ignored when grant_valid=0.
- grant_idx  output  3  index of current owner; registered; feeds decoder select.
- grant_valid  output  1  grant active; registered; feeds decoder enable.
- expired  output  1  one-cycle pulse when a grant is force-released by the MAX_HOLD limit.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE, grant_valid=0, grant_idx=0, expired=0, ptr=0, hold_cnt=0.
  - Takes effect mid-grant: the grant is dropped the following cycle with no expired pulse.
- State IDLE:
  - If req==0: stay in IDLE, outputs hold, grant_valid=0.
  - Else: select the first set bit of req scanning ptr, ptr+1, ..., ptr+7 (mod 8).
  - Next edge: grant_idx=selected, grant_valid=1, hold_cnt=0, state=GRANT.
  - Latency: req seen at edge t → grant_valid=1 after edge t.
- State GRANT: release condition R = done OR (req[grant_idx]==0) OR (hold_cnt==MAX_HOLD-1).
  - If R: next edge grant_valid=0, ptr=grant_idx+1 (3-bit wrap, 7→0), state=IDLE, grant_idx holds its value.
  - Also on R: expired=1 for that one cycle only if done=0, req[grant_idx]=1 and the hold limit was hit.
  - Else: hold_cnt increments; grant_idx and grant_valid hold.
  - Hold time: grant_valid high for at most MAX_HOLD cycles.
- Dead cycle: after any release, grant_valid is 0 for at least one full cycle before the next grant. The decoder output is never switched directly between two one-hot codes.
- Simultaneous events:
  - done together with the hold limit → treated as done; expired=0.
  - New requests arriving during GRANT are only evaluated in IDLE.
- Fairness: a requester that keeps req asserted is granted within 7 other grants.
- req changes for non-owners during GRANT have no effect.
- done while in IDLE is ignored.
- expired is 0 in all cycles not described above.

Test Plan:
- Reset: assert rst_n=0 for 2 cycles with req=8'hFF → grant_valid=0, grant_idx=0, expired=0. Release rst_n → grant_valid=1, grant_idx=0 one cycle later.
- Rotation: req=8'hFF held, done pulsed 1 cycle after each grant → grant_idx sequence 0,1,2,...,7,0. grant_valid low exactly one cycle between grants.
- Wrap/priority: ptr=6 (after granting 5), req=8'b0000_0011 → grant_idx=0. Then with done, req=8'b1000_0001 → grant_idx=7 (ptr=1 scans 1..7 first).
- Timeout: MAX_HOLD=4, req=8'h04 held, done=0 → grant_valid high exactly 4 cycles. expired=1 in the release cycle. grant_idx=2 is regranted after 1 dead cycle.
- Drop release: grant to idx 3, deassert req[3] with done=0 → grant_valid=0 next cycle, expired=0.
- Reset mid-grant: grant active on idx 5, rst_n=0 one cycle → grant_valid=0, ptr=0. With req=8'h21 after reset → grant_idx=0.

Source files
------------

// File: rtl/rr_arbiter_3to8_src.sv
// Round-robin arbiter for 8 requesters.
// Drives a 3-to-8 decoder: grant_idx is the decoder select and grant_valid
// is the decoder enable, so the decoder output is the one-hot grant vector.
//
// Handshake: a requester holds req[i] high for as long as it wants the
// resource. Ownership starts on the edge after req is seen in IDLE.
// Ownership ends on the edge after any of these: done is high, the owner's
// req bit is low, or the hold limit is reached. done has no effect unless
// grant_valid is high.
//
// After every release the FSM spends at least one cycle in IDLE with
// grant_valid low. This dead cycle stops the decoder from switching
// directly from one one-hot code to another.
module rr_arbiter_3to8_src #(
   parameter  int MAX_HOLD = 16,
   localparam int CNT_W    = $clog2(MAX_HOLD)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       done,
   output logic [2:0] grant_idx,
   output logic       grant_valid,
   output logic       expired
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t           state_q;
   logic [2:0]       grant_idx_q;
   logic             grant_valid_q;
   logic             expired_q;
   logic [2:0]       ptr_q;
   logic [CNT_W-1:0] hold_cnt_q;

   logic             pick_found;
   logic [2:0]       pick_idx;
   logic             hold_hit;
   logic             owner_req;
   logic             rel_cond;
   logic             expire_cond;

   // Choose the first requester at or after ptr, wrapping modulo 8.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = ptr_q;
      for (int k = 0; k < 8; k++) begin
         logic [2:0] idx;
         idx = ptr_q + 3'(k);
         if (!pick_found && req[idx]) begin
            pick_found = 1'b1;
            pick_idx   = idx;
         end
      end
   end

   // Work out whether the grant is released, and whether the hold limit
   // alone caused that release.
   always_comb begin
      hold_hit    = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
      owner_req   = req[grant_idx_q];
      rel_cond    = done | ~owner_req | hold_hit;
      expire_cond = ~done & owner_req & hold_hit;
   end

   // Arbiter FSM. Every output is a register, so the decoder always sees
   // clean select and enable inputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         grant_idx_q   <= 3'd0;
         grant_valid_q <= 1'b0;
         expired_q     <= 1'b0;
         ptr_q         <= 3'd0;
         hold_cnt_q    <= '0;
      end else begin
         expired_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pick_found) begin
                  grant_idx_q   <= pick_idx;
                  grant_valid_q <= 1'b1;
                  hold_cnt_q    <= '0;
                  state_q       <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (rel_cond) begin
                  // grant_idx keeps its value. The decoder is disabled
                  // through grant_valid alone.
                  grant_valid_q <= 1'b0;
                  ptr_q         <= grant_idx_q + 3'd1;
                  expired_q     <= expire_cond;
                  state_q       <= ST_IDLE;
               end else begin
                  hold_cnt_q <= hold_cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q       <= ST_IDLE;
               grant_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign grant_idx   = grant_idx_q;
   assign grant_valid = grant_valid_q;
   assign expired     = expired_q;

endmodule

// File: tb/tb_rr_arbiter_3to8_src.sv
// Directed testbench for rr_arbiter_3to8_src.
// There are two instances. The default instance (MAX_HOLD=16) covers reset,
// rotation, wrap, drop release and reset during a grant. A second instance
// with MAX_HOLD=4 covers the hold-limit timeout.
module tb_rr_arbiter_3to8_src;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       done;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       expired;

   logic       rst4_n;
   logic [7:0] req4;
   logic       done4;
   logic [2:0] grant_idx4;
   logic       grant_valid4;
   logic       expired4;

   int n_cmp;
   int n_fail;

   rr_arbiter_3to8_src dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .done        (done),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .expired     (expired)
   );

   rr_arbiter_3to8_src #(.MAX_HOLD(4)) dut4 (
      .clk         (clk),
      .rst_n       (rst4_n),
      .req         (req4),
      .done        (done4),
      .grant_idx   (grant_idx4),
      .grant_valid (grant_valid4),
      .expired     (expired4)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit after it. Inputs are
   // driven and outputs sampled at this point.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = 8'hFF; done = 1'b0;
      tick(); tick();
      n_cmp++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_gv: got %b want 0", grant_valid); end
      n_cmp++; if (grant_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", grant_idx); end
      n_cmp++; if (expired !== 1'b0) begin n_fail++; $display("FAIL reset_exp: got %b want 0", expired); end
      rst_n = 1'b1;
      tick();
      n_cmp++; if (grant_valid !== 1'b1 || grant_idx !== 3'd0) begin n_fail++; $display("FAIL reset_first_grant: got gv=%b idx=%0d want gv=1 idx=0", grant_valid, grant_idx); end
   endtask

   task automatic test_rotation();
      // Owner 0 is granted on entry. With req=FF, pulse done once per grant.
      for (int i = 1; i <= 8; i++) begin
         logic [2:0] exp_idx;
         exp_idx = 3'(i % 8);
         done = 1'b1;
         tick();
         done = 1'b0;
         n_cmp++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL rot_dead_%0d: got gv=%b want 0", i, grant_valid); end
         tick();
         n_cmp++; if (grant_valid !== 1'b1 || grant_idx !== exp_idx) begin n_fail++; $display("FAIL rot_grant_%0d: got gv=%b idx=%0d want gv=1 idx=%0d", i, grant_valid, grant_idx, exp_idx); end
      end
      // Release owner 0, so ptr = 1.
      done = 1'b1;
      tick();
      done = 1'b0;
   endtask

   task automatic test_wrap_priority();
      req = 8'h20;
      tick();
      n_cmp++; if (grant_idx !== 3'd5) begin n_fail++; $display("FAIL wrap_setup5: got %0d want 5", grant_idx); end
      done = 1'b1; req = 8'h03;
      tick();   // release of owner 5, so ptr = 6
      done = 1'b0;
      tick();   // scan 6, 7, 0 picks 0
      n_cmp++; if (grant_valid !== 1'b1 || grant_idx !== 3'd0) begin n_fail++; $display("FAIL wrap_idx0: got gv=%b idx=%0d want gv=1 idx=0", grant_valid, grant_idx); end
      done = 1'b1; req = 8'h81;
      tick();   // release of owner 0, so ptr = 1
      done = 1'b0;
      tick();   // scan 1..7 picks 7 before 0
      n_cmp++; if (grant_valid !== 1'b1 || grant_idx !== 3'd7) begin n_fail++; $display("FAIL wrap_idx7: got gv=%b idx=%0d want gv=1 idx=7", grant_valid, grant_idx); end
   endtask

   task automatic test_non_owner_and_drop();
      // Owner 7 is granted. Changing other req bits has no effect.
      req = 8'hFF;
      tick();
      n_cmp++; if (grant_valid !== 1'b1 || grant_idx !== 3'd7) begin n_fail++; $display("FAIL non_owner_hold: got gv=%b idx=%0d want gv=1 idx=7", grant_valid, grant_idx); end
      // Owner 7 drops its req, so ptr = 0. Requester 3 waits.
      req = 8'h08;
      tick();
      n_cmp++; if (grant_valid !== 1'b0 || expired !== 1'b0) begin n_fail++; $display("FAIL drop7: got gv=%b exp=%b want gv=0 exp=0", grant_valid, expired); end
      tick();
      n_cmp++; if (grant_valid !== 1'b1 || grant_idx !== 3'd3) begin n_fail++; $display("FAIL drop_grant3: got gv=%b idx=%0d want gv=1 idx=3", grant_valid, grant_idx); end
      req = 8'h00;
      tick();   // owner 3 drops, so ptr = 4
      n_cmp++; if (grant_valid !== 1'b0 || expired !== 1'b0) begin n_fail++; $display("FAIL drop3: got gv=%b exp=%b want gv=0 exp=0", grant_valid, expired); end
      // done in IDLE is ignored.
      done = 1'b1;
      tick();
      done = 1'b0;
      n_cmp++; if (grant_valid !== 1'b0 || expired !== 1'b0) begin n_fail++; $display("FAIL idle_done: got gv=%b exp=%b want gv=0 exp=0", grant_valid, expired); end
   endtask

   task automatic test_reset_mid_grant();
      req = 8'h20;
      tick();
      n_cmp++; if (grant_valid !== 1'b1 || grant_idx !== 3'd5) begin n_fail++; $display("FAIL mid_setup5: got gv=%b idx=%0d want gv=1 idx=5", grant_valid, grant_idx); end
      rst_n = 1'b0;
      tick();
      n_cmp++; if (grant_valid !== 1'b0 || expired !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got gv=%b exp=%b want gv=0 exp=0", grant_valid, expired); end
      rst_n = 1'b1; req = 8'h21;
      tick();   // ptr is 0 again, so 0 wins over 5
      n_cmp++; if (grant_valid !== 1'b1 || grant_idx !== 3'd0) begin n_fail++; $display("FAIL mid_regrant: got gv=%b idx=%0d want gv=1 idx=0", grant_valid, grant_idx); end
   endtask

   task automatic test_timeout();
      rst4_n = 1'b0; req4 = 8'h00; done4 = 1'b0;
      tick();
      rst4_n = 1'b1; req4 = 8'h04;
      tick();
      n_cmp++; if (grant_valid4 !== 1'b1 || grant_idx4 !== 3'd2 || expired4 !== 1'b0) begin n_fail++; $display("FAIL to_grant: got gv=%b idx=%0d exp=%b want 1/2/0", grant_valid4, grant_idx4, expired4); end
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_cmp++; if (grant_valid4 !== 1'b1 || expired4 !== 1'b0) begin n_fail++; $display("FAIL to_hold_%0d: got gv=%b exp=%b want gv=1 exp=0", i, grant_valid4, expired4); end
      end
      tick();
      n_cmp++; if (grant_valid4 !== 1'b0 || expired4 !== 1'b1) begin n_fail++; $display("FAIL to_expire: got gv=%b exp=%b want gv=0 exp=1", grant_valid4, expired4); end
      tick();
      n_cmp++; if (grant_valid4 !== 1'b1 || grant_idx4 !== 3'd2 || expired4 !== 1'b0) begin n_fail++; $display("FAIL to_regrant: got gv=%b idx=%0d exp=%b want 1/2/0", grant_valid4, grant_idx4, expired4); end
      // done arriving together with the hold limit counts as done.
      tick(); tick(); tick();
      done4 = 1'b1;
      tick();
      done4 = 1'b0;
      n_cmp++; if (grant_valid4 !== 1'b0 || expired4 !== 1'b0) begin n_fail++; $display("FAIL to_done_at_limit: got gv=%b exp=%b want gv=0 exp=0", grant_valid4, expired4); end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst_n  = 1'b0; req  = 8'h00; done  = 1'b0;
      rst4_n = 1'b0; req4 = 8'h00; done4 = 1'b0;
      test_reset();
      test_rotation();
      test_wrap_priority();
      test_non_owner_and_drop();
      test_reset_mid_grant();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
